// File: rtl/lock_pkg.sv
// Shared constants and state encoding for the password-setting and unlock blocks.
package lock_pkg;

    localparam int DIGITS  = 4;
    localparam int DIGIT_W = 4;
    localparam int PW_W    = DIGITS * DIGIT_W;
    localparam int DCNT_W  = 3;

    typedef enum logic [2:0] {
        NO_PW,
        ENTRY,
        CHECK,
        OPEN,
        LOCKOUT
    } lock_state_t;

endpackage

// File: rtl/lock_timeout_counter.sv
// Start/done counter: o_done is high in the last of CYCLES counted cycles after i_start.
module lock_timeout_counter #(
    parameter int CYCLES = 100000000,
    parameter int CNT_W  = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_abort,
    output logic o_done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_run;

    assign o_done = r_run && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || i_abort) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_run <= 1'b1;
            r_cnt <= '0;
        end else if (r_run) begin
            if (o_done) begin
                r_run <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lock_verify.sv
// Unlock FSM: collects four digits, compares against the stored password,
// counts consecutive failures and holds a timed lockout after too many.
module lock_verify
    import lock_pkg::*;
#(
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 100000000,
    parameter int CNT_W          = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enter,
    input  logic              clear,
    input  logic              relock,
    input  logic [DIGIT_W-1:0] switch,
    input  logic [PW_W-1:0]   password,
    input  logic              pw_valid,
    output logic              unlocked,
    output logic              fail,
    output logic              locked_out,
    output logic [DCNT_W-1:0] digit_cnt,
    output logic [2:0]        attempts_left
);

    localparam logic [2:0]        ATT_MAX  = 3'(MAX_ATTEMPTS);
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DIGITS);

    lock_state_t       r_state, w_state_nxt;
    logic [PW_W-1:0]   r_buf, w_buf_nxt;
    logic [DCNT_W-1:0] r_digit_cnt, w_digit_cnt_nxt;
    logic [2:0]        r_attempts, w_attempts_nxt;
    logic              r_unlocked, w_unlocked_nxt;
    logic              r_fail, w_fail_nxt;
    logic              r_locked_out, w_locked_out_nxt;
    logic              w_tmr_start, w_tmr_abort, w_tmr_done;

    lock_timeout_counter #(
        .CYCLES (LOCKOUT_CYCLES),
        .CNT_W  (CNT_W)
    ) u_tmr (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_tmr_start),
        .i_abort (w_tmr_abort),
        .o_done  (w_tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= NO_PW;
            r_buf        <= '0;
            r_digit_cnt  <= '0;
            r_attempts   <= ATT_MAX;
            r_unlocked   <= 1'b0;
            r_fail       <= 1'b0;
            r_locked_out <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_buf        <= w_buf_nxt;
            r_digit_cnt  <= w_digit_cnt_nxt;
            r_attempts   <= w_attempts_nxt;
            r_unlocked   <= w_unlocked_nxt;
            r_fail       <= w_fail_nxt;
            r_locked_out <= w_locked_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_buf_nxt        = r_buf;
        w_digit_cnt_nxt  = r_digit_cnt;
        w_attempts_nxt   = r_attempts;
        w_unlocked_nxt   = r_unlocked;
        w_fail_nxt       = 1'b0;
        w_locked_out_nxt = r_locked_out;
        w_tmr_start      = 1'b0;
        w_tmr_abort      = 1'b0;

        // Losing the password outranks everything the FSM might be doing.
        if (!pw_valid && r_state != NO_PW) begin
            w_state_nxt      = NO_PW;
            w_buf_nxt        = '0;
            w_digit_cnt_nxt  = '0;
            w_unlocked_nxt   = 1'b0;
            w_locked_out_nxt = 1'b0;
            w_attempts_nxt   = ATT_MAX;
            w_tmr_abort      = 1'b1;
        end else begin
            unique case (r_state)
                NO_PW: begin
                    if (pw_valid) begin
                        w_state_nxt     = ENTRY;
                        w_digit_cnt_nxt = '0;
                    end
                end
                ENTRY: begin
                    if (clear) begin
                        w_buf_nxt       = '0;
                        w_digit_cnt_nxt = '0;
                    end else if (enter && r_digit_cnt < DCNT_MAX) begin
                        w_buf_nxt[r_digit_cnt[1:0]*DIGIT_W +: DIGIT_W] = switch;
                        w_digit_cnt_nxt = r_digit_cnt + 1'b1;
                        if (r_digit_cnt == DCNT_MAX - 1'b1)
                            w_state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    // The entered code is never retained past the compare.
                    w_buf_nxt       = '0;
                    w_digit_cnt_nxt = '0;
                    if (r_buf == password) begin
                        w_state_nxt    = OPEN;
                        w_unlocked_nxt = 1'b1;
                        w_attempts_nxt = ATT_MAX;
                    end else begin
                        w_fail_nxt     = 1'b1;
                        w_attempts_nxt = r_attempts - 1'b1;
                        if (r_attempts == 3'd1) begin
                            w_state_nxt      = LOCKOUT;
                            w_locked_out_nxt = 1'b1;
                            w_tmr_start      = 1'b1;
                        end else begin
                            w_state_nxt = ENTRY;
                        end
                    end
                end
                OPEN: begin
                    if (relock) begin
                        w_unlocked_nxt = 1'b0;
                        w_state_nxt    = ENTRY;
                    end
                end
                LOCKOUT: begin
                    if (w_tmr_done) begin
                        w_locked_out_nxt = 1'b0;
                        w_attempts_nxt   = ATT_MAX;
                        w_state_nxt      = ENTRY;
                    end
                end
                default: begin
                    w_state_nxt = NO_PW;
                end
            endcase
        end
    end

    assign unlocked      = r_unlocked;
    assign fail          = r_fail;
    assign locked_out    = r_locked_out;
    assign digit_cnt     = r_digit_cnt;
    assign attempts_left = r_attempts;

endmodule

// File: tb/tb_lock_verify.sv
// Scoreboard bench for lock_verify: stimulus pushes expected unlock/fail/lockout
// events, an edge monitor pops and compares them as the outputs appear.
module tb_lock_verify;

    localparam int MAXA = 3;
    localparam int LOC  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enter = 1'b0;
    logic        clear = 1'b0;
    logic        relock = 1'b0;
    logic [3:0]  switch = 4'h0;
    logic [15:0] password = 16'h4321;
    logic        pw_valid = 1'b0;
    logic        unlocked, fail, locked_out;
    logic [2:0]  digit_cnt, attempts_left;

    lock_verify #(
        .MAX_ATTEMPTS   (MAXA),
        .LOCKOUT_CYCLES (LOC),
        .CNT_W          (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enter         (enter),
        .clear         (clear),
        .relock        (relock),
        .switch        (switch),
        .password      (password),
        .pw_valid      (pw_valid),
        .unlocked      (unlocked),
        .fail          (fail),
        .locked_out    (locked_out),
        .digit_cnt     (digit_cnt),
        .attempts_left (attempts_left)
    );

    always #5 clk = ~clk;

    // kind: 0 unlock, 1 fail, 2 end of lockout
    typedef struct {
        int kind;
        int val;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   exp_att = MAXA;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic prev_unl = 1'b0, prev_fail = 1'b0, prev_lo = 1'b0;
    int   fw = 0, lo_len = 0;

    task automatic sb_take(input int kind);
        exp_t e;
        chk("sb_nonempty", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("ev_kind", kind, e.kind);
            if (kind == 2) begin
                chk("lockout_len", lo_len, e.val);
            end else begin
                chk(kind == 0 ? "unlock_lat" : "fail_lat", cyc, e.cyc);
                chk(kind == 0 ? "unlock_att" : "fail_att", int'(attempts_left), e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            fw     = 0;
            lo_len = 0;
        end else begin
            if (unlocked && !prev_unl) sb_take(0);
            if (fail && !prev_fail) sb_take(1);
            if (fail) fw++;
            else if (fw != 0) begin
                chk("fail_width", fw, 1);
                fw = 0;
            end
            if (locked_out) lo_len++;
            else if (prev_lo) begin
                sb_take(2);
                lo_len = 0;
            end
        end
        prev_unl  = unlocked;
        prev_fail = fail;
        prev_lo   = locked_out;
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_digit(input logic [3:0] d, input logic clr, output int c);
        @(negedge clk);
        switch = d;
        enter  = 1'b1;
        clear  = clr;
        c      = cyc;
        @(negedge clk);
        enter = 1'b0;
        clear = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] code);
        int   c;
        exp_t e;
        for (int i = 0; i < 4; i++) drive_digit(code[4*i +: 4], 1'b0, c);
        if (code == password) begin
            exp_att = MAXA;
            e = '{0, MAXA, c + 2};
            q.push_back(e);
        end else begin
            exp_att--;
            e = '{1, exp_att, c + 2};
            q.push_back(e);
            if (exp_att == 0) begin
                e = '{2, LOC, 0};
                q.push_back(e);
                exp_att = MAXA;
            end
        end
    endtask

    task automatic do_relock();
        @(negedge clk);
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
    endtask

    initial begin
        int c;
        int n;

        idle(2);
        rst = 1'b0;
        chk("rst_unlocked", int'(unlocked), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_locked_out", int'(locked_out), 0);
        chk("rst_digit_cnt", int'(digit_cnt), 0);
        chk("rst_attempts", int'(attempts_left), MAXA);

        // no password yet: enter ignored
        drive_digit(4'h1, 1'b0, c);
        chk("nopw_digit_cnt", int'(digit_cnt), 0);

        // correct code
        pw_valid = 1'b1;
        idle(2);
        for (int i = 0; i < 3; i++) drive_digit(4'(i + 1), 1'b0, c);
        chk("partial_digit_cnt", int'(digit_cnt), 3);
        drive_digit(4'h4, 1'b0, c);
        begin
            exp_t e;
            e = '{0, MAXA, c + 2};
            q.push_back(e);
        end
        idle(2);
        chk("open_unlocked", int'(unlocked), 1);
        drive_digit(4'h6, 1'b0, c);
        chk("open_enter_ignored", int'(digit_cnt), 0);
        do_relock();
        chk("relock_unlocked", int'(unlocked), 0);
        chk("relock_digit_cnt", int'(digit_cnt), 0);

        // single mismatch, then a good code restores attempts
        enter_code(16'h5321);
        idle(3);
        chk("mis_unlocked", int'(unlocked), 0);
        chk("mis_digit_cnt", int'(digit_cnt), 0);
        chk("mis_attempts", int'(attempts_left), 2);
        enter_code(16'h4321);
        idle(3);
        do_relock();

        // three wrong codes -> lockout
        enter_code(16'h1111);
        idle(2);
        enter_code(16'h2222);
        idle(2);
        enter_code(16'h3333);
        idle(2);
        drive_digit(4'h5, 1'b0, c);
        chk("lo_enter_ignored", int'(digit_cnt), 0);
        chk("lo_active", int'(locked_out), 1);
        n = 0;
        while (locked_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("lo_wait_bound", int'(n < 40), 1);
        idle(1);
        chk("lo_attempts_restored", int'(attempts_left), MAXA);
        enter_code(16'h4321);
        idle(3);
        chk("post_lo_unlocked", int'(unlocked), 1);
        do_relock();

        // clear together with enter drops the digit
        drive_digit(4'h1, 1'b0, c);
        drive_digit(4'h2, 1'b0, c);
        drive_digit(4'h9, 1'b1, c);
        chk("clear_digit_cnt", int'(digit_cnt), 0);
        enter_code(16'h4321);
        idle(3);
        do_relock();

        // password changes mid-entry: compare uses the new value
        drive_digit(4'h1, 1'b0, c);
        drive_digit(4'h2, 1'b0, c);
        drive_digit(4'h3, 1'b0, c);
        password = 16'h7321;
        drive_digit(4'h7, 1'b0, c);
        begin
            exp_t e;
            e = '{0, MAXA, c + 2};
            q.push_back(e);
        end
        idle(3);
        do_relock();
        password = 16'h4321;

        // pw_valid drop mid-entry
        drive_digit(4'h1, 1'b0, c);
        drive_digit(4'h2, 1'b0, c);
        pw_valid = 1'b0;
        idle(1);
        chk("pwdrop_digit_cnt", int'(digit_cnt), 0);
        drive_digit(4'h3, 1'b0, c);
        chk("pwdrop_enter_ignored", int'(digit_cnt), 0);
        pw_valid = 1'b1;
        idle(2);
        enter_code(16'h4321);
        idle(3);
        chk("pwback_unlocked", int'(unlocked), 1);

        // reset while open
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_open_unlocked", int'(unlocked), 0);
        chk("rst_open_fail", int'(fail), 0);
        chk("rst_open_locked_out", int'(locked_out), 0);
        chk("rst_open_digit_cnt", int'(digit_cnt), 0);
        chk("rst_open_attempts", int'(attempts_left), MAXA);

        idle(3);
        chk("sb_drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
